// File: rtl/mips_pipe_pkg.sv
// Shared pipeline constants and the occupancy view of the two-entry skid register.
package mips_pipe_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Occupancy is derived purely from the two valid bits.
    function automatic occ_e occ_decode(input logic main_valid, input logic skid_valid);
        if (skid_valid) begin
            return OCC_FULL;
        end
        if (main_valid) begin
            return OCC_ONE;
        end
        return OCC_EMPTY;
    endfunction

endpackage

// File: rtl/skid_entry.sv
// Payload register with load enable and asynchronous active-low clear.
module skid_entry #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: fully registered valid/ready handshake with 1-cycle latency.
// Optional synchronous flush port compiled in with PIPE_SKID_FLUSH_EN.
module pipe_skid_reg
    import mips_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PIPE_SKID_FLUSH_EN
    input  logic             flush,
`endif
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             main_load, skid_load;
    logic [WIDTH-1:0] main_data_d;
    logic [WIDTH-1:0] main_data, skid_data;
    logic             in_xfer, out_xfer;
    logic             flush_c;

`ifdef PIPE_SKID_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data;

    assign in_xfer  = in_valid && !skid_valid_q;
    assign out_xfer = main_valid_q && out_ready;

    // When draining from FULL the skid word refills main; otherwise main takes the input.
    assign main_data_d = skid_valid_q ? skid_data : in_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_load    = 1'b0;
        skid_load    = 1'b0;

        case (occ_decode(main_valid_q, skid_valid_q))
            OCC_EMPTY: begin
                if (in_xfer) begin
                    main_load    = 1'b1;
                    main_valid_d = 1'b1;
                end
            end
            OCC_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_load = 1'b1;
                end else if (in_xfer) begin
                    skid_load    = 1'b1;
                    skid_valid_d = 1'b1;
                end else if (out_xfer) begin
                    main_valid_d = 1'b0;
                end
            end
            OCC_FULL: begin
                if (out_xfer) begin
                    main_load    = 1'b1;
                    skid_valid_d = 1'b0;
                end
            end
            default: begin
                main_valid_d = 1'b0;
                skid_valid_d = 1'b0;
            end
        endcase

        // Flush drops every held word and swallows this cycle's input.
        if (flush_c) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_load    = 1'b0;
            skid_load    = 1'b0;
        end
    end

    skid_entry #(.WIDTH(WIDTH)) u_main (
        .clk    (clk),
        .rst_n  (rst),
        .load_i (main_load),
        .d_i    (main_data_d),
        .q_o    (main_data)
    );

    skid_entry #(.WIDTH(WIDTH)) u_skid (
        .clk    (clk),
        .rst_n  (rst),
        .load_i (skid_load),
        .d_i    (in_data),
        .q_o    (skid_data)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed vectors plus an order-checking output monitor.
module tb_pipe_skid_reg;
    import mips_pipe_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
`ifdef PIPE_SKID_FLUSH_EN
    logic              flush = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    logic [DATA_W-1:0] exp_q[$];

    pipe_skid_reg #(.WIDTH(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PIPE_SKID_FLUSH_EN
        .flush     (flush),
`endif
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
    endtask

    // Monitor: mid-cycle, score any output transfer against the oldest accepted word, then record new acceptances.
    always @(negedge clk) begin
        logic flushing;
        flushing = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
        flushing = flush;
`endif
        if (!rst || flushing) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", out_data, 'x);
                end else begin
                    check("scoreboard_data", out_data, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
            end
        end
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b0;

        // Reset held with in_valid asserted.
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_data",  out_data,       32'd0);
        step();
        step();
        check("rst_hold_out_valid", 32'(out_valid), 32'd0);
        check("rst_hold_out_data",  out_data,       32'd0);
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Streaming: one word per cycle, one-cycle latency.
        out_ready = 1'b1;
        send(32'h11);
        check("stream_v0", 32'(out_valid), 32'd1);
        check("stream_d0", out_data, 32'h11);
        send(32'h22);
        check("stream_d1", out_data, 32'h22);
        check("stream_rdy1", 32'(in_ready), 32'd1);
        send(32'h33);
        check("stream_v2", 32'(out_valid), 32'd1);
        check("stream_d2", out_data, 32'h33);
        in_valid = 1'b0;
        step();
        check("stream_drained", 32'(out_valid), 32'd0);

        // Backpressure into FULL, then drain in order.
        out_ready = 1'b0;
        send(32'hA);
        check("bp_one_rdy", 32'(in_ready), 32'd1);
        send(32'hB);
        check("bp_full_rdy", 32'(in_ready), 32'd0);
        check("bp_full_v",   32'(out_valid), 32'd1);
        check("bp_full_d",   out_data, 32'hA);
        send(32'hCC);
        check("bp_hold_d",   out_data, 32'hA);
        check("bp_hold_rdy", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_drain_d",   out_data, 32'hB);
        check("bp_drain_rdy", 32'(in_ready), 32'd1);
        step();
        check("bp_empty_v", 32'(out_valid), 32'd0);

        // Simultaneous in/out transfer while ONE.
        out_ready = 1'b0;
        send(32'h5);
        check("sim_main", out_data, 32'h5);
        out_ready = 1'b1;
        send(32'h6);
        check("sim_reload_d",   out_data, 32'h6);
        check("sim_reload_rdy", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        step();
        check("sim_skid_empty", 32'(out_valid), 32'd0);

        // Reset mid-operation from FULL.
        out_ready = 1'b0;
        send(32'h1);
        send(32'h2);
        check("mid_full_rdy", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check("mid_rst_v",   32'(out_valid), 32'd0);
        check("mid_rst_rdy", 32'(in_ready),  32'd1);
        check("mid_rst_d",   out_data,       32'd0);
        step();
        rst       = 1'b1;
        out_ready = 1'b1;
        send(32'h3);
        check("mid_after_d", out_data, 32'h3);
        in_valid = 1'b0;
        step();
        check("mid_after_alone", 32'(out_valid), 32'd0);

`ifdef PIPE_SKID_FLUSH_EN
        // Flush from FULL swallows the concurrent input.
        out_ready = 1'b0;
        send(32'h7);
        send(32'h8);
        check("fl_full_rdy", 32'(in_ready), 32'd0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h9;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_v", 32'(out_valid), 32'd0);
        check("fl_rdy",   32'(in_ready),  32'd1);
        out_ready = 1'b1;
        step();
        check("fl_no_9", 32'(out_valid), 32'd0);
`endif

        step();
        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the payload width in bits.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-low; clears all state when low.
REQ-004 in_valid  input  1  upstream has a word on in_data.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 in_data  input  WIDTH  upstream payload.
REQ-007 out_valid  output  1  out_data holds a valid word.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_data  output  WIDTH  downstream payload.
REQ-010 flush  input  1  discard all held words; present only with PIPE_SKID_FLUSH_EN.

Function
REQ-011 SHALL hold two entries: main (drives out_*) and skid (overflow); each has a data register and a valid bit.
REQ-012 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-013 in_ready SHALL equal !skid_valid, driven directly from a flop with no combinational path from out_ready.
REQ-014 out_valid SHALL equal main_valid; out_data SHALL equal main_data, both driven directly from flops.
REQ-015 Latency SHALL be 1 cycle: a word accepted at edge N is visible on out_* after edge N when main is empty or being drained.
REQ-016 State EMPTY (main and skid invalid): input transfer -> main loaded -> ONE.
REQ-017 State ONE (main valid, skid invalid): input and output transfers together -> main reloaded, stay ONE; input only -> word to skid -> FULL; output only -> EMPTY.
REQ-018 State FULL (both valid, in_ready=0): output transfer -> skid moves to main, skid cleared -> ONE; otherwise hold.
REQ-019 Words SHALL leave in acceptance order; no word SHALL be dropped or duplicated.
REQ-020 Sustained in_valid=out_ready=1 SHALL give one word per cycle.
REQ-021 in_data SHALL be ignored when no input transfer occurs; data registers SHALL not load without a transfer.
REQ-022 out_data SHALL stay stable while out_valid=1 and out_ready=0.

Reset
REQ-023 rst low SHALL immediately clear main_valid and skid_valid, giving out_valid=0 and in_ready=1.
REQ-024 rst low SHALL clear both data registers to 0, giving out_data=0.
REQ-025 Reset asserted mid-operation SHALL discard held words; the first accepted word after deassertion behaves as from EMPTY.

Configuration
REQ-026 Macro PIPE_SKID_FLUSH_EN SHALL compile in the flush port.
REQ-027 With PIPE_SKID_FLUSH_EN defined, flush=1 at an edge SHALL clear both valid bits, ignore any input transfer that cycle, and give in_ready=1 the next cycle; data registers may keep their values.
REQ-028 Without PIPE_SKID_FLUSH_EN, the flush port SHALL not exist and behaviour SHALL be REQ-011..REQ-025 only.

Structure
REQ-029 Shared package mips_pipe_pkg SHALL hold the constant DATA_W=32, which sets WIDTH at instantiation sites.
REQ-030 One sub-module, skid_entry, SHALL be used twice: a WIDTH-wide register with load enable and async active-low clear.
REQ-031 State SHALL be encoded only by the two valid bits; no separate state register.

Verification
REQ-032 Reset: rst=0 with in_valid=1 -> out_valid=0, in_ready=1, out_data=0.
REQ-033 Streaming: out_ready=1, send 0x11, 0x22, 0x33 on consecutive cycles -> out_data reads 0x11, 0x22, 0x33 one cycle later each, no gaps.
REQ-034 Backpressure: out_ready=0, send 0xA and 0xB -> FULL, in_ready=0, out_data=0xA held; raise out_ready -> 0xA then 0xB, then in_ready=1.
REQ-035 Simultaneous transfer in ONE: main=0x5, in 0x6, out_ready=1 -> next cycle out_data=0x6, skid stays empty.
REQ-036 Reset mid-operation: FULL with 0x1 and 0x2, rst=0 for one cycle -> both discarded; next word 0x3 appears alone.
REQ-037 Flush (PIPE_SKID_FLUSH_EN): FULL, flush=1 with in_valid=1, in_data=0x9 -> out_valid=0, in_ready=1, and 0x9 never appears.
